adder_result_fifo: RTL

Result-capture stage downstream of the ripple-carry adder. Each cycle it can accept the adder's DATA_WIDTH+1-bit extended sum and the operand sign bits. It derives carry, signed-overflow and zero flags, then buffers result plus flags in a DEPTH-entry FIFO. Results leave through a valid/ready interface, which decouples the combinational adder from a back-pressuring consumer such as a scoreboard port or register-file write-back.

---
 rtl/adder_result_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/adder_result_fifo.sv
// Result-capture FIFO behind the ripple-carry adder. It derives carry,
// signed-overflow and zero flags when each result is pushed, and stores
// them with the sum in a DEPTH-entry circular buffer.
// Latency: one cycle from the push edge to the head when the FIFO was empty.
// There is no forwarding path.
// Backpressure: in_ready depends only on occupancy, flush and rst_n, and never
// on out_ready, so a full FIFO refuses a push even in a cycle with a pop.
// The head fields are held stable until the entry is popped or flushed.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               synchronous clear of all buffered entries
//   in_valid/in_ready   upstream handshake. Data is in_sum_ext plus the
//                       operand MSBs.
//   out_valid/out_ready downstream handshake. The head is out_sum with the
//                       out_carry, out_ovf and out_zero flags.
//   count               occupancy, 0..DEPTH
module adder_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH:0]        in_sum_ext,
  input  logic                       in_a_msb,
  input  logic                       in_b_msb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_sum,
  output logic                       out_carry,
  output logic                       out_ovf,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry;
    logic                  ovf;
    logic                  zero;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t in_entry;
  logic   push;
  logic   pop;

  // The flags are computed here from the inputs, so the consumer never sees
  // the adder's combinational path.
  always_comb begin
    in_entry.sum   = in_sum_ext[DATA_WIDTH-1:0];
    in_entry.carry = in_sum_ext[DATA_WIDTH];
    // Signed overflow: the operands have the same sign and the result sign
    // differs from it.
    in_entry.ovf   = (in_a_msb == in_b_msb) && (in_sum_ext[DATA_WIDTH-1] != in_a_msb);
    // The carry-out is deliberately excluded from the zero test.
    in_entry.zero  = (in_sum_ext[DATA_WIDTH-1:0] == '0);
  end

  assign in_ready  = rst_n && !flush && (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head is a show-ahead read: a combinational mux over registered
  // storage.
  assign out_sum   = mem_q[rd_ptr_q].sum;
  assign out_carry = mem_q[rd_ptr_q].carry;
  assign out_ovf   = mem_q[rd_ptr_q].ovf;
  assign out_zero  = mem_q[rd_ptr_q].zero;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over any pop. A push cannot happen here because in_ready
      // is already low. Storage contents are left as they are.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
